// File: rtl/heap_op_scheduler_pkg.sv
// Shared definitions for the heap custom-instruction scheduler and its decode.
// Opcode values are the custom-instruction encodings.
package heap_op_scheduler_pkg;

   localparam int DATA_W = 32;
   localparam int TAG_W  = 5;

   typedef enum logic [1:0] {
      OP_PUSH  = 2'b00,
      OP_POP   = 2'b01,
      OP_SIZE  = 2'b10,
      OP_CLEAR = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ISSUE = 2'b01,
      ST_WAIT  = 2'b10,
      ST_RESP  = 2'b11
   } state_e;

   // Index width for a requester id; a single requester still needs one bit.
   function automatic int ptr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/heap_op_scheduler_if.sv
// Requester request/response bus plus the engine command/completion bus.
interface heap_op_scheduler_if
   import heap_op_scheduler_pkg::*;
#(
   parameter int NREQ = 2
);
   logic [NREQ-1:0]        req_v;
   logic [2*NREQ-1:0]      req_op;
   logic [DATA_W*NREQ-1:0] req_data;
   logic [TAG_W*NREQ-1:0]  req_rd;
   logic [NREQ-1:0]        req_ready;
   logic [NREQ-1:0]        resp_v;
   logic [TAG_W-1:0]       resp_rd;
   logic [DATA_W-1:0]      resp_data;
   logic                   resp_err;
   logic                   eng_start;
   logic [1:0]             eng_op;
   logic [DATA_W-1:0]      eng_data;
   logic                   eng_abort;
   logic                   eng_done;
   logic [DATA_W-1:0]      eng_rdata;

   modport master (
      output req_v, req_op, req_data, req_rd, eng_done, eng_rdata,
      input  req_ready, resp_v, resp_rd, resp_data, resp_err,
             eng_start, eng_op, eng_data, eng_abort
   );

   modport slave (
      input  req_v, req_op, req_data, req_rd, eng_done, eng_rdata,
      output req_ready, resp_v, resp_rd, resp_data, resp_err,
             eng_start, eng_op, eng_data, eng_abort
   );
endinterface

// File: rtl/heap_op_scheduler_rr_arbiter.sv
// Round-robin grant: first asserted request at or above ptr, wrapping.
// Purely combinational so a shared unit can accept in the same cycle.
module rr_arbiter
   import heap_op_scheduler_pkg::*;
#(
   parameter int N  = 2,
   parameter int PW = ptr_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [PW-1:0] grant_id
);

   always_comb begin
      int   idx;
      logic found;
      grant    = '0;
      grant_id = '0;
      found    = 1'b0;
      idx      = 0;
      for (int i = 0; i < N; i++) begin
         idx = (int'(ptr) + i) % N;
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            grant_id   = PW'(idx);
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/heap_op_scheduler.sv
// Shares one multi-cycle heap engine between NREQ requesters, tracking occupancy
// locally so impossible PUSH/POP are answered without touching the engine.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | arbitrate; reject / answer SIZE directly, else go issue
// ST_ISSUE | eng_start pulse, timeout counter loaded
// ST_WAIT  | wait for eng_done or timeout (abort)
// ST_RESP  | one-cycle resp_v to the originating requester, advance rr_ptr
module heap_op_scheduler
   import heap_op_scheduler_pkg::*;
#(
   parameter int NREQ      = 2,
   parameter int HEAP_SIZE = 11,
   parameter int CNT_W     = $clog2(HEAP_SIZE + 1),
   parameter int TIMEOUT   = 64
) (
   input  logic              clk,
   input  logic              reset,
   heap_op_scheduler_if.slave bus,
   output logic [CNT_W-1:0]  heap_count,
   output logic              heap_full,
   output logic              heap_empty
);

   localparam int PW    = ptr_w(NREQ);
   localparam int TMR_W = $clog2(TIMEOUT + 1);

   state_e              state_q, state_d;
   logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [TMR_W-1:0]    tmr_q, tmr_d;
   op_e                 op_q, op_d;
   logic [TAG_W-1:0]    rd_q, rd_d;
   logic [PW-1:0]       id_q, id_d;
   logic                eng_start_q, eng_start_d;
   logic [1:0]          eng_op_q, eng_op_d;
   logic [DATA_W-1:0]   eng_data_q, eng_data_d;
   logic                eng_abort_q, eng_abort_d;
   logic [NREQ-1:0]     resp_v_q, resp_v_d;
   logic [TAG_W-1:0]    resp_rd_q, resp_rd_d;
   logic [DATA_W-1:0]   resp_data_q, resp_data_d;
   logic                resp_err_q, resp_err_d;

   logic [NREQ-1:0]     arb_req, grant;
   logic [PW-1:0]       g_id;
   op_e                 g_op;
   logic [DATA_W-1:0]   g_data;
   logic [TAG_W-1:0]    g_rd;
   logic                full, empty;

   assign arb_req = (state_q == ST_IDLE) ? bus.req_v : '0;

   rr_arbiter #(.N(NREQ), .PW(PW)) u_arb (
      .req      (arb_req),
      .ptr      (rr_ptr_q),
      .grant    (grant),
      .grant_id (g_id)
   );

   assign g_op   = op_e'(bus.req_op[2*g_id +: 2]);
   assign g_data = bus.req_data[DATA_W*g_id +: DATA_W];
   assign g_rd   = bus.req_rd[TAG_W*g_id +: TAG_W];
   assign full   = (count_q == CNT_W'(HEAP_SIZE));
   assign empty  = (count_q == '0);

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      count_d     = count_q;
      tmr_d       = tmr_q;
      op_d        = op_q;
      rd_d        = rd_q;
      id_d        = id_q;
      eng_start_d = 1'b0;
      eng_op_d    = eng_op_q;
      eng_data_d  = eng_data_q;
      eng_abort_d = 1'b0;
      resp_v_d    = '0;
      resp_rd_d   = resp_rd_q;
      resp_data_d = resp_data_q;
      resp_err_d  = resp_err_q;
      case (state_q)
         ST_IDLE: begin
            if (|grant) begin
               op_d = g_op;
               rd_d = g_rd;
               id_d = g_id;
               if ((g_op == OP_PUSH && full) || (g_op == OP_POP && empty)) begin
                  state_d        = ST_RESP;
                  resp_v_d[g_id] = 1'b1;
                  resp_rd_d      = g_rd;
                  resp_data_d    = '0;
                  resp_err_d     = 1'b1;
               end else if (g_op == OP_SIZE) begin
                  state_d        = ST_RESP;
                  resp_v_d[g_id] = 1'b1;
                  resp_rd_d      = g_rd;
                  resp_data_d    = DATA_W'(count_q);
                  resp_err_d     = 1'b0;
               end else begin
                  state_d     = ST_ISSUE;
                  eng_start_d = 1'b1;
                  eng_op_d    = g_op;
                  eng_data_d  = g_data;
               end
            end
         end
         ST_ISSUE: begin
            state_d = ST_WAIT;
            tmr_d   = TMR_W'(TIMEOUT);
         end
         ST_WAIT: begin
            // Completion wins over timeout when both land in the last cycle.
            if (bus.eng_done) begin
               case (op_q)
                  OP_PUSH:  count_d = count_q + CNT_W'(1);
                  OP_POP:   count_d = count_q - CNT_W'(1);
                  OP_CLEAR: count_d = '0;
                  default:  count_d = count_q;
               endcase
               state_d        = ST_RESP;
               resp_v_d[id_q] = 1'b1;
               resp_rd_d      = rd_q;
               resp_data_d    = (op_q == OP_POP) ? bus.eng_rdata : '0;
               resp_err_d     = 1'b0;
            end else if (tmr_q == TMR_W'(1)) begin
               state_d        = ST_RESP;
               eng_abort_d    = 1'b1;
               resp_v_d[id_q] = 1'b1;
               resp_rd_d      = rd_q;
               resp_data_d    = '0;
               resp_err_d     = 1'b1;
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
         ST_RESP: begin
            state_d  = ST_IDLE;
            rr_ptr_d = (id_q == PW'(NREQ - 1)) ? '0 : id_q + PW'(1);
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         rr_ptr_q    <= '0;
         count_q     <= '0;
         tmr_q       <= '0;
         op_q        <= OP_PUSH;
         rd_q        <= '0;
         id_q        <= '0;
         eng_start_q <= 1'b0;
         eng_op_q    <= '0;
         eng_data_q  <= '0;
         eng_abort_q <= 1'b0;
         resp_v_q    <= '0;
         resp_rd_q   <= '0;
         resp_data_q <= '0;
         resp_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         count_q     <= count_d;
         tmr_q       <= tmr_d;
         op_q        <= op_d;
         rd_q        <= rd_d;
         id_q        <= id_d;
         eng_start_q <= eng_start_d;
         eng_op_q    <= eng_op_d;
         eng_data_q  <= eng_data_d;
         eng_abort_q <= eng_abort_d;
         resp_v_q    <= resp_v_d;
         resp_rd_q   <= resp_rd_d;
         resp_data_q <= resp_data_d;
         resp_err_q  <= resp_err_d;
      end
   end

   assign bus.req_ready = grant;
   assign bus.resp_v    = resp_v_q;
   assign bus.resp_rd   = resp_rd_q;
   assign bus.resp_data = resp_data_q;
   assign bus.resp_err  = resp_err_q;
   assign bus.eng_start = eng_start_q;
   assign bus.eng_op    = eng_op_q;
   assign bus.eng_data  = eng_data_q;
   assign bus.eng_abort = eng_abort_q;
   assign heap_count    = count_q;
   assign heap_full     = full;
   assign heap_empty    = empty;

endmodule

// File: tb/tb_heap_op_scheduler.sv
// Directed scoreboard bench for heap_op_scheduler with a behavioural engine.
module tb_heap_op_scheduler;
   import heap_op_scheduler_pkg::*;

   typedef struct {
      int          id;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  heap_count;
   logic        heap_full, heap_empty;

   heap_op_scheduler_if #(.NREQ(2)) bus ();

   heap_op_scheduler #(.NREQ(2), .HEAP_SIZE(11), .TIMEOUT(64)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .heap_count (heap_count),
      .heap_full  (heap_full),
      .heap_empty (heap_empty)
   );

   always #5 clk = ~clk;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          n_start = 0, n_abort = 0, n_resp = 0;
   int          start_cyc = 0, done_cyc = 0, abort_cyc = 0, resp_cyc = 0;
   logic [31:0] start_data = '0;
   logic [1:0]  start_op = '0;
   int          eng_lat = 1;
   logic [31:0] pop_val = '0;
   bit          spur = 1'b0;

   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Engine model: eng_done eng_lat cycles after eng_start; lat 0 = never answers.
   initial begin : engine
      bit pend;
      int left;
      pend = 1'b0;
      left = 0;
      bus.eng_done  = 1'b0;
      bus.eng_rdata = '0;
      forever begin
         @(posedge clk);
         #2;
         bus.eng_done = 1'b0;
         if (!reset) begin
            pend = 1'b0;
         end else begin
            if (pend) begin
               left--;
               if (left == 0) begin
                  bus.eng_done  = 1'b1;
                  bus.eng_rdata = pop_val;
                  pend          = 1'b0;
               end
            end
            if (bus.eng_start && eng_lat > 0) begin
               pend = 1'b1;
               left = eng_lat;
            end
            if (spur) begin
               bus.eng_done = 1'b1;
               spur         = 1'b0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (bus.eng_start) begin
         n_start++;
         start_cyc  = cyc;
         start_data = bus.eng_data;
         start_op   = bus.eng_op;
      end
      if (bus.eng_done) done_cyc = cyc;
      if (bus.eng_abort) begin
         n_abort++;
         abort_cyc = cyc;
      end
      if (|bus.resp_v) begin
         n_resp++;
         resp_cyc = cyc;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_resp resp_v=%b rd=%0d data=%0h err=%b", bus.resp_v,
                     bus.resp_rd, bus.resp_data, bus.resp_err);
         end else begin
            exp_t e;
            logic [1:0] ev;
            e  = exp_q.pop_front();
            ev = 2'b01 << e.id;
            if (bus.resp_v !== ev || bus.resp_rd !== e.rd || bus.resp_data !== e.data ||
                bus.resp_err !== e.err) begin
               errors++;
               $display("FAIL resp actual v=%b rd=%0d data=%0h err=%b required v=%b rd=%0d data=%0h err=%b",
                        bus.resp_v, bus.resp_rd, bus.resp_data, bus.resp_err, ev, e.rd, e.data, e.err);
            end
         end
      end
   end

   task automatic set_req(input int id, input logic [1:0] op, input logic [31:0] d,
                          input logic [4:0] rd, input logic [31:0] ed, input logic ee);
      exp_t e;
      bus.req_op[2*id +: 2]    = op;
      bus.req_data[32*id +: 32] = d;
      bus.req_rd[5*id +: 5]    = rd;
      bus.req_v[id]            = 1'b1;
      e.id = id; e.rd = rd; e.data = ed; e.err = ee;
      exp_q.push_back(e);
   endtask

   task automatic wait_accept(input int id, output int acc);
      bit got;
      got = 1'b0;
      acc = -1;
      for (int n = 0; n < 300 && !got; n++) begin
         #1;
         if (bus.req_ready[id]) begin
            @(posedge clk);
            #1;
            acc           = cyc;
            got           = 1'b1;
            bus.req_v[id] = 1'b0;
         end else begin
            @(negedge clk);
         end
      end
      chk($sformatf("accept_req%0d", id), got, 1'b1);
   endtask

   task automatic wait_drain();
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         #2;
         if (exp_q.size() == 0) break;
      end
      chk("drain", exp_q.size(), 0);
      @(negedge clk);
   endtask

   task automatic do_req(input int id, input logic [1:0] op, input logic [31:0] d,
                         input logic [4:0] rd, input logic [31:0] ed, input logic ee,
                         output int acc);
      @(negedge clk);
      set_req(id, op, d, rd, ed, ee);
      wait_accept(id, acc);
      wait_drain();
   endtask

   task automatic chk_reset_outputs(input string name);
      chk(name, {bus.resp_v, bus.resp_rd, bus.resp_data, bus.resp_err, bus.eng_start,
                 bus.eng_op, bus.eng_data, bus.eng_abort, bus.req_ready, heap_count,
                 heap_full, heap_empty}, 128'h1);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset     = 1'b0;
      bus.req_v = '0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int a0, a1, s, r;
      reset        = 1'b0;
      bus.req_v    = '0;
      bus.req_op   = '0;
      bus.req_data = '0;
      bus.req_rd   = '0;
      repeat (2) @(negedge clk);
      #1;
      chk_reset_outputs("reset_state");
      reset = 1'b1;

      // single push, engine answers after 3 cycles
      eng_lat = 3;
      do_req(0, OP_PUSH, 32'd5, 5'd3, 32'd0, 1'b0, a0);
      chk("t1_start_lat", start_cyc, a0);
      chk("t1_eng_data", start_data, 32'd5);
      chk("t1_eng_op", start_op, OP_PUSH);
      chk("t1_done_lat", done_cyc, start_cyc + 3);
      chk("t1_resp_lat", resp_cyc, done_cyc + 1);
      chk("t1_count", heap_count, 4'd1);

      // simultaneous requests from reset: req0 first, req1 next IDLE
      apply_reset();
      @(negedge clk);
      set_req(0, OP_PUSH, 32'd7, 5'd10, 32'd0, 1'b0);
      set_req(1, OP_PUSH, 32'd9, 5'd20, 32'd0, 1'b0);
      wait_accept(0, a0);
      wait_accept(1, a1);
      wait_drain();
      chk("t2_second_grant_cyc", a1, a0 + 6);
      chk("t2_eng_data", start_data, 32'd9);
      chk("t2_count", heap_count, 4'd2);

      // clear, then pop when empty
      eng_lat = 2;
      do_req(0, OP_CLEAR, 32'd0, 5'd6, 32'd0, 1'b0, a0);
      chk("t3_clear_count", heap_count, 4'd0);
      chk("t3_clear_empty", heap_empty, 1'b1);
      s = n_start;
      do_req(1, OP_POP, 32'd0, 5'd7, 32'd0, 1'b1, a0);
      chk("t3_pop_empty_no_start", n_start, s);
      chk("t3_pop_empty_resp_lat", resp_cyc, a0);

      // fill to capacity, reject the 12th push, then pop
      eng_lat = 1;
      for (int i = 0; i < 11; i++) begin
         do_req(i % 2, OP_PUSH, 32'(100 + i), 5'(i), 32'd0, 1'b0, a0);
      end
      chk("t4_count_full", heap_count, 4'd11);
      chk("t4_full_flag", heap_full, 1'b1);
      s = n_start;
      do_req(0, OP_PUSH, 32'd200, 5'd11, 32'd0, 1'b1, a0);
      chk("t4_reject_no_start", n_start, s);
      chk("t4_reject_resp_lat", resp_cyc, a0);
      chk("t4_still_full", heap_count, 4'd11);
      eng_lat = 2;
      pop_val = 32'h2A;
      do_req(1, OP_POP, 32'd0, 5'd12, 32'h2A, 1'b0, a0);
      chk("t4_pop_count", heap_count, 4'd10);
      chk("t4_pop_not_full", heap_full, 1'b0);

      // stray eng_done while idle is ignored
      r = n_resp;
      @(negedge clk);
      spur = 1'b1;
      repeat (4) @(negedge clk);
      chk("stray_done_count", heap_count, 4'd10);
      chk("stray_done_no_resp", n_resp, r);

      // SIZE after three pushes, then CLEAR
      apply_reset();
      eng_lat = 2;
      for (int i = 0; i < 3; i++) begin
         do_req(1, OP_PUSH, 32'(i + 1), 5'(i + 1), 32'd0, 1'b0, a0);
      end
      s = n_start;
      do_req(0, OP_SIZE, 32'd0, 5'd4, 32'd3, 1'b0, a0);
      chk("t5_size_no_start", n_start, s);
      chk("t5_size_resp_lat", resp_cyc, a0);
      do_req(1, OP_CLEAR, 32'd0, 5'd5, 32'd0, 1'b0, a0);
      chk("t5_clear_op", start_op, OP_CLEAR);
      chk("t5_clear_count", heap_count, 4'd0);
      chk("t5_clear_empty", heap_empty, 1'b1);

      // engine never answers: abort after 64 WAIT cycles
      eng_lat = 0;
      do_req(0, OP_PUSH, 32'h55, 5'd8, 32'd0, 1'b1, a0);
      chk("t6_abort_cyc", abort_cyc, start_cyc + 65);
      chk("t6_abort_pulses", n_abort, 1);
      chk("t6_abort_resp_cyc", resp_cyc, abort_cyc);
      chk("t6_count_unchanged", heap_count, 4'd0);

      // reset mid-WAIT drops the request with no response
      eng_lat = 2;
      do_req(1, OP_PUSH, 32'h66, 5'd9, 32'd0, 1'b0, a0);
      chk("t6_count_one", heap_count, 4'd1);
      eng_lat = 0;
      @(negedge clk);
      set_req(0, OP_PUSH, 32'h77, 5'd10, 32'd0, 1'b0);
      wait_accept(0, a0);
      r = n_resp;
      repeat (5) @(negedge clk);
      reset = 1'b0;
      #1;
      chk_reset_outputs("t6_mid_wait_reset");
      exp_q.delete();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (10) @(negedge clk);
      chk("t6_no_resp_after_reset", n_resp, r);
      chk("t6_count_after_reset", heap_count, 4'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
